seq_alu: RTL

Parametrised, handshaked, multi-cycle ALU. It is the next generation of the team's 8-bit combinational add/sub/xor/shift ALU. It adds a configurable width, registered flags, a shift-add multiply that takes WIDTH cycles, and valid/ready flow control on both sides, so it can sit between a producer and a consumer without either side dropping an operation.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_mul.sv | 61 ++++++
 rtl/seq_alu.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, op width and FSM states.
package alu_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD = 3'b000;
    localparam op_t OP_SUB = 3'b001;
    localparam op_t OP_XOR = 3'b010;
    localparam op_t OP_SHL = 3'b011;
    localparam op_t OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Producer/consumer handshake bundle for seq_alu; slave is the ALU side.
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );

endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier, one multiplier bit per cycle, LSB first.
// product/done are look-ahead so the caller can register the final sum on the last step.
module seq_alu_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    assign done    = (cnt_q == CW'(1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/xor/shl, WIDTH-cycle multiply,
// registered result and flags held in DONE until the consumer takes them.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    seq_alu_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry;
    logic               sc_err;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [2*WIDTH-1:0] shl_full;

    assign bus.in_ready  = (state_q == ST_IDLE) && rst_n;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.op == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        add_full  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full  = {1'b0, bus.a} - {1'b0, bus.b};
        shl_full  = {{WIDTH{1'b0}}, bus.a} << bus.b;
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_err    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_carry  = add_full[WIDTH];
            end
            OP_SUB: begin
                sc_result = sub_full[WIDTH-1:0];
                sc_carry  = sub_full[WIDTH];
            end
            OP_XOR: sc_result = bus.a ^ bus.b;
            OP_SHL: begin
                // Oversized shifts lose every bit of a.
                if (bus.b >= WIDTH'(WIDTH)) begin
                    sc_carry = |bus.a;
                end else begin
                    sc_result = shl_full[WIDTH-1:0];
                    sc_carry  = |shl_full[2*WIDTH-1:WIDTH];
                end
            end
            OP_MUL: ;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_result;
                        carry_d  = sc_carry;
                        zero_d   = (sc_result == '0);
                        err_d    = sc_err;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_prod[WIDTH-1:0];
                    carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_prod[WIDTH-1:0] == '0);
                    err_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule
